// File: rtl/cic_channel_scheduler.sv
// Two-channel (left/right) sample buffer feeding one shared CIC engine, one job at a time.
// Round-robin arbitration, per-job cic_done timeout, sticky overflow/timeout flags.
module cic_channel_scheduler #(
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          sysclk,
  input  logic          RST,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_vld,
  input  logic          sample_ch,
  input  logic          cic_done,
  input  logic          clr_err,
  output logic          cic_start,
  output logic [DW-1:0] cic_din,
  output logic          cic_ch,
  output logic          busy,
  output logic          ovf_l,
  output logic          ovf_r,
  output logic          timeout_err
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e        state;
  logic [DW-1:0] buf_l, buf_r;
  logic          full_l, full_r;
  logic          last_ch;
  logic [7:0]    cnt;

  logic issue, pick_r, free_l, free_r;
  logic vld_l, vld_r, acc_l, acc_r, drop_l, drop_r;
  logic to_hit;

  always_comb begin
    issue  = (state == StIdle) && (full_l || full_r);
    // Right wins only if left is empty or left was served last.
    pick_r = full_r && (!full_l || !last_ch);
    free_l = issue && !pick_r;
    free_r = issue && pick_r;
    vld_l  = sample_vld && !sample_ch;
    vld_r  = sample_vld && sample_ch;
    // A buffer freed on this edge may accept the incoming word.
    acc_l  = vld_l && (!full_l || free_l);
    acc_r  = vld_r && (!full_r || free_r);
    drop_l = vld_l && full_l && !free_l;
    drop_r = vld_r && full_r && !free_r;
    to_hit = (state == StWait) && !cic_done && (cnt == TimeoutCnt);
  end

  always_ff @(posedge sysclk or negedge RST) begin
    if (!RST) begin
      state       <= StIdle;
      buf_l       <= '0;
      buf_r       <= '0;
      full_l      <= 1'b0;
      full_r      <= 1'b0;
      last_ch     <= 1'b1;
      cnt         <= '0;
      cic_start   <= 1'b0;
      cic_din     <= '0;
      cic_ch      <= 1'b0;
      busy        <= 1'b0;
      ovf_l       <= 1'b0;
      ovf_r       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (acc_l) begin
        buf_l  <= sample_in;
        full_l <= 1'b1;
      end else if (free_l) begin
        full_l <= 1'b0;
      end
      if (acc_r) begin
        buf_r  <= sample_in;
        full_r <= 1'b1;
      end else if (free_r) begin
        full_r <= 1'b0;
      end

      // Set beats clear.
      ovf_l       <= (ovf_l & ~clr_err) | drop_l;
      ovf_r       <= (ovf_r & ~clr_err) | drop_r;
      timeout_err <= (timeout_err & ~clr_err) | to_hit;

      unique case (state)
        StIdle: begin
          cic_start <= 1'b0;
          cnt       <= '0;
          if (issue) begin
            state     <= StIssue;
            cic_start <= 1'b1;
            busy      <= 1'b1;
            cic_din   <= pick_r ? buf_r : buf_l;
            cic_ch    <= pick_r;
            last_ch   <= pick_r;
          end
        end
        StIssue: begin
          state     <= StWait;
          cic_start <= 1'b0;
          cnt       <= '0;
        end
        StWait: begin
          if (cic_done || to_hit) begin
            state <= StIdle;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state     <= StIdle;
          cic_start <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cic_channel_scheduler.sv
// Directed bench for cic_channel_scheduler with TIMEOUT = 4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_cic_channel_scheduler;

  localparam int unsigned DW = 16;

  logic          sysclk = 1'b0;
  logic          RST;
  logic [DW-1:0] sample_in;
  logic          sample_vld, sample_ch, cic_done, clr_err;
  logic          cic_start, cic_ch, busy, ovf_l, ovf_r, timeout_err;
  logic [DW-1:0] cic_din;

  int checks = 0;
  int errors = 0;

  cic_channel_scheduler #(.DW(DW), .TIMEOUT(4)) dut (
    .sysclk      (sysclk),
    .RST         (RST),
    .sample_in   (sample_in),
    .sample_vld  (sample_vld),
    .sample_ch   (sample_ch),
    .cic_done    (cic_done),
    .clr_err     (clr_err),
    .cic_start   (cic_start),
    .cic_din     (cic_din),
    .cic_ch      (cic_ch),
    .busy        (busy),
    .ovf_l       (ovf_l),
    .ovf_r       (ovf_r),
    .timeout_err (timeout_err)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic strobe(input logic ch, input logic [DW-1:0] val);
    sample_vld = 1'b1;
    sample_ch  = ch;
    sample_in  = val;
    tick();
    sample_vld = 1'b0;
  endtask

  // Waits (bounded) for cic_start, then checks the issued word and channel.
  task automatic expect_job(input string tag, input logic [DW-1:0] din, input logic ch);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = cic_start;
    end
    check_eq({tag, "_start"}, 32'(seen), 32'd1);
    check_eq({tag, "_din"}, 32'(cic_din), 32'(din));
    check_eq({tag, "_ch"}, 32'(cic_ch), 32'(ch));
  endtask

  task automatic finish_job();
    cic_done = 1'b1;
    tick();
    cic_done = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int starts;
    RST = 1'b0; sample_in = '0; sample_vld = 1'b0; sample_ch = 1'b0;
    cic_done = 1'b0; clr_err = 1'b0;
    tick(); tick();
    check_eq("rst_start", 32'(cic_start), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_din", 32'(cic_din), 32'd0);
    check_eq("rst_flags", 32'({ovf_l, ovf_r, timeout_err, cic_ch}), 32'd0);
    RST = 1'b1;
    tick();

    // Single job; done arrives on the same cycle the counter reaches TIMEOUT.
    strobe(1'b0, 16'h1234);
    check_eq("single_no_early_start", 32'(cic_start), 32'd0);
    tick();
    check_eq("single_start_lat", 32'(cic_start), 32'd1);
    check_eq("single_din", 32'(cic_din), 32'h1234);
    check_eq("single_ch", 32'(cic_ch), 32'd0);
    busy_cnt = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      busy_cnt += int'(busy);
    end
    finish_job();
    check_eq("single_busy_cycles", 32'(busy_cnt), 32'd6);
    check_eq("single_busy_off", 32'(busy), 32'd0);
    check_eq("single_no_flags", 32'({ovf_l, ovf_r, timeout_err}), 32'd0);

    // Round robin: last served left, so right goes first when both are full.
    strobe(1'b0, 16'h1111);
    expect_job("rr0", 16'h1111, 1'b0);
    strobe(1'b0, 16'hAAAA);
    strobe(1'b1, 16'h5555);
    finish_job();
    expect_job("rr1", 16'h5555, 1'b1);
    tick();
    finish_job();
    expect_job("rr2", 16'hAAAA, 1'b0);
    tick();
    finish_job();

    // Overflow on left while it is buffered behind a right job.
    strobe(1'b1, 16'h0BBB);
    expect_job("ov0", 16'h0BBB, 1'b1);
    strobe(1'b0, 16'h0001);
    strobe(1'b0, 16'h0002);
    check_eq("ov_ovf_l_set", 32'(ovf_l), 32'd1);
    finish_job();
    expect_job("ov1", 16'h0001, 1'b0);
    check_eq("ov_ovf_r_clear", 32'(ovf_r), 32'd0);
    tick();
    finish_job();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_eq("ov_clr", 32'(ovf_l), 32'd0);

    // Timeout with right sample waiting behind.
    strobe(1'b0, 16'h0C0C);
    expect_job("to0", 16'h0C0C, 1'b0);
    strobe(1'b1, 16'h0D0D);
    for (int i = 0; i < 4; i++) tick();
    check_eq("to_not_yet", 32'(timeout_err), 32'd0);
    check_eq("to_still_busy", 32'(busy), 32'd1);
    tick();
    check_eq("to_err_set", 32'(timeout_err), 32'd1);
    check_eq("to_busy_off", 32'(busy), 32'd0);
    expect_job("to1", 16'h0D0D, 1'b1);
    tick();
    finish_job();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_eq("to_clr", 32'(timeout_err), 32'd0);

    // New left word on the edge that issues the left buffer.
    strobe(1'b0, 16'h0E0E);
    sample_vld = 1'b1; sample_ch = 1'b0; sample_in = 16'h0F0F;
    tick();
    sample_vld = 1'b0;
    check_eq("co_start", 32'(cic_start), 32'd1);
    check_eq("co_din", 32'(cic_din), 32'h0E0E);
    check_eq("co_no_ovf", 32'(ovf_l), 32'd0);
    // cic_done during ISSUE must be ignored.
    cic_done = 1'b1;
    tick();
    cic_done = 1'b0;
    check_eq("co_done_in_issue", 32'(busy), 32'd1);
    finish_job();
    expect_job("co1", 16'h0F0F, 1'b0);
    tick();
    finish_job();

    // Reset mid-WAIT with right buffer full.
    strobe(1'b0, 16'h1010);
    expect_job("rs0", 16'h1010, 1'b0);
    strobe(1'b1, 16'h2020);
    #2;
    RST = 1'b0;
    #1;
    check_eq("rs_async_busy", 32'(busy), 32'd0);
    check_eq("rs_async_din", 32'(cic_din), 32'd0);
    check_eq("rs_async_misc", 32'({cic_start, cic_ch, ovf_l, ovf_r, timeout_err}), 32'd0);
    tick(); tick();
    RST = 1'b1;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      starts += int'(cic_start);
    end
    check_eq("rs_no_start", 32'(starts), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
